// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer.
// Holds the program counter, drives the word address of a combinational
// instruction memory and streams fetched words to decode through a 1-entry
// output register with a valid/ready handshake. Supports redirects, restart
// after halt, and halting on a run of all-zero words or at the end of memory.
//
// Ports:
//   Clock, ResetN        rising-edge clock, async active-low reset
//   Start                IDLE->RUN; in HALT restarts from address 0
//   Redirect/RedirectAddr load PC and flush the output register
//   ReadAddress          memory word address (always equals PC)
//   Instruction          memory read data for ReadAddress (same cycle)
//   InstrOut/InstrPC     registered word and its address
//   InstrValid/InstrReady output handshake
//   Halted, Busy         state == HALT, state == RUN
module instruction_fetch_sequencer #(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 32,
  parameter int NOP_HALT_COUNT = 4,
  parameter int WRAP           = 0
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Start,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectAddr,
  output logic [ADDR_W-1:0] ReadAddress,
  input  logic [DATA_W-1:0] Instruction,
  output logic [DATA_W-1:0] InstrOut,
  output logic [ADDR_W-1:0] InstrPC,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic              Halted,
  output logic              Busy
);

  // Counter must still be at least 1 bit when the zero-halt is disabled.
  localparam int ZC_W = (NOP_HALT_COUNT > 0) ? $clog2(NOP_HALT_COUNT + 1) : 1;
  localparam logic [ADDR_W-1:0] PC_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ZC_W-1:0]   zero_cnt_q, zero_cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              vld_q, vld_d;

  logic slot_free, handshake, zero_word, zero_halt;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    zero_cnt_d = zero_cnt_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    vld_d      = vld_q;

    slot_free = !vld_q || InstrReady;
    handshake = vld_q && InstrReady;
    zero_word = (Instruction == '0);
    // The Nth consecutive zero word halts instead of being presented.
    zero_halt = (NOP_HALT_COUNT != 0) && zero_word &&
                (zero_cnt_q == ZC_W'(NOP_HALT_COUNT - 1));

    unique case (state_q)
      S_IDLE: begin
        if (Redirect) pc_d = RedirectAddr;
        if (Start)    state_d = S_RUN;
      end
      S_RUN: begin
        if (Redirect) begin
          // Any handshake this cycle consumes the old word; nothing new is captured.
          pc_d       = RedirectAddr;
          vld_d      = 1'b0;
          zero_cnt_d = '0;
        end else if (slot_free) begin
          if (zero_halt) begin
            state_d = S_HALT;
            vld_d   = 1'b0;
          end else begin
            instr_d    = Instruction;
            instr_pc_d = pc_q;
            vld_d      = 1'b1;
            if (!zero_word)             zero_cnt_d = '0;
            else if (zero_cnt_q != '1)  zero_cnt_d = zero_cnt_q + ZC_W'(1);
            // Without wrap the last word is still presented; PC parks on it.
            if (pc_q == PC_LAST && WRAP == 0) state_d = S_HALT;
            else                              pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      S_HALT: begin
        if (handshake) vld_d = 1'b0;
        if (Start) begin
          pc_d       = '0;
          zero_cnt_d = '0;
          vld_d      = 1'b0;
          state_d    = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      zero_cnt_q <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      zero_cnt_q <= zero_cnt_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      vld_q      <= vld_d;
    end
  end

  assign ReadAddress = pc_q;
  assign InstrOut    = instr_q;
  assign InstrPC     = instr_pc_q;
  assign InstrValid  = vld_q;
  assign Halted      = (state_q == S_HALT);
  assign Busy        = (state_q == S_RUN);

endmodule
